// File: rtl/add64_pkg.sv
// ----------------------------------------------------------------------------
// add64_pkg
// Shared widths and FSM state encoding for the two-pass 64-bit add/subtract
// sequencer (add64_seq) and its 32-bit ripple-carry adder slice.
//   WORD_W        : adder slice width (fixed at 32)
//   DWORD_W       : operand/result width (2 x WORD_W)
//   add64_state_t : IDLE -> LO -> HI -> DONE sequencing states
// ----------------------------------------------------------------------------
package add64_pkg;

   localparam int WORD_W  = 32;
   localparam int DWORD_W = 2 * WORD_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } add64_state_t;

endpackage

// File: rtl/u_32b_add_2.sv
// ----------------------------------------------------------------------------
// u_32b_add_2
// 32-bit ripple-carry adder slice. Purely combinational.
// Ports:
//   in1  [31:0] in  : first operand
//   in2  [31:0] in  : second operand
//   cin1        in  : carry into bit 0
//   sout [31:0] out : sum bits
//   cout [31:0] out : carry out of every bit position; cout[31] is the slice
//                     carry-out, cout[30] is the carry into the sign bit
// ----------------------------------------------------------------------------
module u_32b_add_2
   import add64_pkg::*;
(
   input  logic [WORD_W-1:0] in1,
   input  logic [WORD_W-1:0] in2,
   input  logic              cin1,
   output logic [WORD_W-1:0] sout,
   output logic [WORD_W-1:0] cout
);

   // Ripple the carry bit by bit, exposing every intermediate carry.
   always_comb begin
      logic c_v;
      sout = {WORD_W{1'b0}};
      cout = {WORD_W{1'b0}};
      c_v  = cin1;
      for (int i = 0; i < WORD_W; i++) begin
         sout[i] = in1[i] ^ in2[i] ^ c_v;
         c_v     = (in1[i] & in2[i]) | (c_v & (in1[i] ^ in2[i]));
         cout[i] = c_v;
      end
   end

endmodule

// File: rtl/add64_seq.sv
// ----------------------------------------------------------------------------
// add64_seq
// Two-pass 64-bit add/subtract sequencer. One 32-bit adder slice is used
// twice: the low word first, then the high word with the low-word carry
// chained in. Subtraction is a + ~b + 1, with the inversion applied when the
// operands are captured and the +1 supplied as the low-pass carry-in.
// Ports:
//   clk              in  : clock, rising edge
//   rst              in  : synchronous active-high reset
//   in_valid         in  : operand pair present
//   in_ready         out : accepting operands (IDLE only)
//   op_a     [63:0]  in  : minuend / augend
//   op_b     [63:0]  in  : subtrahend / addend
//   sub              in  : 1 = a - b, 0 = a + b
//   out_valid        out : result registers valid (DONE only)
//   out_ready        in  : consumer accepts the result
//   result   [63:0]  out : a +/- b modulo 2^64
//   carry            out : carry-out of bit 63 (1 = no borrow on subtract)
//   overflow         out : two's-complement overflow
//   zero             out : result is zero
// ----------------------------------------------------------------------------
module add64_seq
   import add64_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DWORD_W-1:0] op_a,
   input  logic [DWORD_W-1:0] op_b,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DWORD_W-1:0] result,
   output logic               carry,
   output logic               overflow,
   output logic               zero
);

   add64_state_t       state_r;
   logic [DWORD_W-1:0] a_r;
   logic [DWORD_W-1:0] b_r;       // already inverted for subtract
   logic               sub_r;
   logic               c_lo_r;
   logic [DWORD_W-1:0] result_r;
   logic               carry_r;
   logic               overflow_r;
   logic               zero_r;

   logic [WORD_W-1:0]  in1_s;
   logic [WORD_W-1:0]  in2_s;
   logic               cin1_s;
   logic [WORD_W-1:0]  sout_s;
   logic [WORD_W-1:0]  cout_s;

   // Adder input select: low word in LO, high word in HI, quiet zeros otherwise.
   always_comb begin
      in1_s  = {WORD_W{1'b0}};
      in2_s  = {WORD_W{1'b0}};
      cin1_s = 1'b0;
      case (state_r)
         LO: begin
            in1_s  = a_r[WORD_W-1:0];
            in2_s  = b_r[WORD_W-1:0];
            cin1_s = sub_r;
         end
         HI: begin
            in1_s  = a_r[DWORD_W-1:WORD_W];
            in2_s  = b_r[DWORD_W-1:WORD_W];
            cin1_s = c_lo_r;
         end
         default: begin
            in1_s  = {WORD_W{1'b0}};
            in2_s  = {WORD_W{1'b0}};
            cin1_s = 1'b0;
         end
      endcase
   end

   u_32b_add_2 u_add (
      .in1  (in1_s),
      .in2  (in2_s),
      .cin1 (cin1_s),
      .sout (sout_s),
      .cout (cout_s)
   );

   // Sequencer FSM with operand capture and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         a_r        <= {DWORD_W{1'b0}};
         b_r        <= {DWORD_W{1'b0}};
         sub_r      <= 1'b0;
         c_lo_r     <= 1'b0;
         result_r   <= {DWORD_W{1'b0}};
         carry_r    <= 1'b0;
         overflow_r <= 1'b0;
         zero_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= op_a;
                  b_r     <= sub ? ~op_b : op_b;
                  sub_r   <= sub;
                  state_r <= LO;
               end
            end
            LO: begin
               result_r[WORD_W-1:0] <= sout_s;
               c_lo_r               <= cout_s[WORD_W-1];
               state_r              <= HI;
            end
            HI: begin
               result_r[DWORD_W-1:WORD_W] <= sout_s;
               carry_r    <= cout_s[WORD_W-1];
               // Carry into the sign bit differs from carry out of it.
               overflow_r <= cout_s[WORD_W-1] ^ cout_s[WORD_W-2];
               zero_r     <= (sout_s == {WORD_W{1'b0}}) &&
                             (result_r[WORD_W-1:0] == {WORD_W{1'b0}});
               state_r    <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign result    = result_r;
   assign carry     = carry_r;
   assign overflow  = overflow_r;
   assign zero      = zero_r;

endmodule

// File: doc/add64_seq.md
# add64_seq

Two-pass 64-bit add/subtract sequencer built around the team's 32-bit ripple-carry adder (`u_32b_add_2`), which it time-multiplexes. It accepts a 64-bit operand pair through a valid/ready handshake. It computes the low word and then the high word, chaining the carry between the two passes. It returns a registered 64-bit result with carry, signed-overflow and zero flags, and sits between the datapath operand registers and result writeback.

## Interface
- `WORD_W`, 32: adder slice width. This value is fixed and must match `u_32b_add_2`.
- `DWORD_W`, 64: operand/result width, 2×`WORD_W`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `op_a`  in  64  minuend/augend.
- `op_b`  in  64  subtrahend/addend.
- `sub`  in  1  1 = a−b, 0 = a+b; sampled with the operands.
- `out_valid`  out  1  result registers valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  64  a±b modulo 2^64.
- `carry`  out  1  carry-out of bit 63. For subtract, 1 = no borrow.
- `overflow`  out  1  two's-complement overflow.
- `zero`  out  1  `result` == 0.

## Operation
- States: IDLE, LO, HI, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: capture `op_a`, capture `op_b` (bitwise-inverted when `sub`=1), capture `sub`; go to LO.
- **LO**
  - Drive the adder with `in1`=a[31:0], `in2`=b'[31:0], `cin1`=sub.
  - Register `sout` into result[31:0] and `cout[31]` into internal `c_lo`; go to HI.
- **HI**
  - Drive the adder with `in1`=a[63:32], `in2`=b'[63:32], `cin1`=`c_lo`.
  - Register:
    - `sout` into result[63:32]
    - `carry`=`cout[31]`
    - `overflow`=`cout[31]`^`cout[30]`
    - `zero`=(`sout`==0)&&(result[31:0]==0)
  - Go to DONE.
- **DONE**
  - `out_valid`=1.
  - On `out_ready`, go to IDLE.
- **Outputs:** `result` and the flags are held stable from DONE entry until the next LO/HI write. They keep the last values after the handshake completes.
- **Adder drive outside LO/HI:** `in1`, `in2` and `cin1` are don't-care. Tie them to 0 in IDLE/DONE to limit toggling.
- **Backpressure:** while in DONE with `out_ready`=0, the block stays in DONE, `in_ready`=0, and `in_valid` is ignored.
- **Reset, all states:** next state IDLE, `out_valid`=0, `result`=0, `carry`=0, `overflow`=0, `zero`=0, `c_lo`=0, operand registers=0. An in-flight operation is discarded and never produces a result.
- **Reset priority:** `rst` has priority over `in_valid` and `out_ready` in the same cycle.

## Timing
- `in_ready`, `out_valid`: decoded combinationally from the state register only, with no input-to-output combinational path.
- **Transfer rule:** a transfer occurs at a rising edge where valid && ready.
- **Latency:** an operand accepted at edge k gives LO during k→k+1, HI during k+1→k+2, and `out_valid`=1 from edge k+2 (two cycles after acceptance).
- **Minimum initiation interval:** 4 cycles. The cycles are accept, LO, HI, DONE with `out_ready`=1, then `in_ready` is high again the cycle after leaving DONE.
- **Adder path:** the critical path is the 32-bit ripple through `u_32b_add_2` within one cycle. There are no multicycle paths.
- **After reset:** the first cycle after the reset edge is IDLE with `in_ready`=1.

## Structure
- Package `add64_pkg`:
  - `WORD_W`, `DWORD_W` localparams.
  - `typedef enum logic [1:0] {IDLE, LO, HI, DONE} add64_state_t`.
- Single sub-module: one instance of `u_32b_add_2`, with its `cout[31:0]` vector consumed for the `carry` and `overflow` taps.
- Top-level contents: FSM, operand/result registers, and the adder input multiplexers (low/high word select, invert-on-sub, carry select).

## Test plan
- **Reset:** hold `rst` for 2 cycles mid-traffic → `out_valid`=0, `result`=0, all flags 0, `in_ready`=1 on the first cycle after release.
- **Carry chain:** add 0x00000000_FFFFFFFF + 0x1 → `result`=0x00000001_00000000, carry=0, overflow=0, zero=0, `out_valid` two cycles after accept.
- **Wrap and overflow on add:**
  - 0xFFFFFFFF_FFFFFFFF + 0x1 → result=0, carry=1, zero=1, overflow=0.
  - 0x7FFFFFFF_FFFFFFFF + 0x1 → result=0x80000000_00000000, overflow=1, carry=0.
- **Subtract:**
  - 5−5 → result=0, carry=1, zero=1.
  - 0−1 → result=0xFFFFFFFF_FFFFFFFF, carry=0, overflow=0.
  - 0x80000000_00000000−1 → overflow=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1 and new operands → result and flags unchanged, `in_ready`=0, no second capture. Release `out_ready` → `in_ready`=1 on the next cycle, then the new op completes correctly.
- **Reset mid-operation:** assert `rst` during HI → next cycle IDLE, `out_valid` never asserts for that op, and a subsequent 2+3 yields 5.
